// File: rtl/sim_ctrl_timers.sv
`default_nettype none
// ============================================================================
// Module   : sim_ctrl_timers
// Purpose  : Memory-mapped simulation control block. It provides a free-running
//            cycle counter with an atomic hi/lo snapshot, a clock-period query,
//            finish with exit code, a watchdog and NUM_TIMERS countdown timers
//            with a maskable interrupt.
// Revision : 1.0 - initial release
// ============================================================================
module sim_ctrl_timers #(
    parameter int CYC_WIDTH     = 64,
    parameter int CLK_PERIOD_PS = 10000,
    parameter int NUM_TIMERS    = 4,
    parameter bit SIM_FINISH    = 1'b1
) (
    input  logic        clk,
    input  logic        nreset,
    input  logic [7:0]  addr,
    input  logic [31:0] wdata,
    input  logic        we,
    input  logic        rd,
    output logic [31:0] rdata,
    output logic        ack,
    output logic        irq,
    output logic        done,
    output logic [7:0]  exit_code
);

    // Word indices (addr[7:2]) of the register map
    localparam logic [5:0] C_IDX_CYC_LO = 6'd0;
    localparam logic [5:0] C_IDX_CYC_HI = 6'd1;
    localparam logic [5:0] C_IDX_PERIOD = 6'd2;
    localparam logic [5:0] C_IDX_FINISH = 6'd3;
    localparam logic [5:0] C_IDX_WDOG   = 6'd4;
    localparam logic [5:0] C_IDX_STATUS = 6'd5;
    localparam logic [5:0] C_IDX_ENABLE = 6'd6;
    localparam logic [5:0] C_IDX_TIMER  = 6'd8;
    localparam logic [5:0] C_IDX_RELOAD = 6'd16;

    logic [CYC_WIDTH-1:0]  cyc_q, cyc_d;
    logic [31:0]           hi_snap_q, hi_snap_d;
    logic [31:0]           rdata_q, rdata_d;
    logic                  ack_q, ack_d;
    logic                  done_q, done_d;
    logic [7:0]            exit_q, exit_d;
    logic [31:0]           wdog_q, wdog_d;
    logic [NUM_TIMERS-1:0] status_q, status_d;
    logic [NUM_TIMERS-1:0] enable_q, enable_d;
    logic [31:0]           tmr_q [NUM_TIMERS];
    logic [31:0]           tmr_d [NUM_TIMERS];
    logic [31:0]           rel_q [NUM_TIMERS];
    logic [31:0]           rel_d [NUM_TIMERS];

    logic [63:0]           w_cyc_ext;
    logic [5:0]            w_idx;
    logic                  w_read;
    logic [31:0]           w_rd_val;
    logic [NUM_TIMERS-1:0] w_set;
    logic                  w_unused_addr;

    assign w_idx         = addr[7:2];
    assign w_unused_addr = ^addr[1:0];
    // A simultaneous write suppresses the read side of the access
    assign w_read        = rd & ~we;
    // Zero-extending makes the upper half naturally 0 for narrow counters
    assign w_cyc_ext     = 64'(cyc_q);

    // Next-state computation for the bus, counter, watchdog and timers
    always_comb begin
        cyc_d     = cyc_q + CYC_WIDTH'(1);
        hi_snap_d = hi_snap_q;
        done_d    = done_q;
        exit_d    = exit_q;
        wdog_d    = wdog_q;
        enable_d  = enable_q;
        tmr_d     = tmr_q;
        rel_d     = rel_q;
        w_set     = '0;
        w_rd_val  = '0;

        // Read mux, built from pre-edge register values
        case (w_idx)
            C_IDX_CYC_LO: w_rd_val = w_cyc_ext[31:0];
            C_IDX_CYC_HI: w_rd_val = hi_snap_q;
            C_IDX_PERIOD: w_rd_val = 32'(CLK_PERIOD_PS);
            C_IDX_WDOG:   w_rd_val = wdog_q;
            C_IDX_STATUS: w_rd_val = 32'(status_q);
            C_IDX_ENABLE: w_rd_val = 32'(enable_q);
            default: begin
                for (int n = 0; n < NUM_TIMERS; n++) begin
                    if (w_idx == C_IDX_TIMER + 6'(n))  w_rd_val = tmr_q[n];
                    if (w_idx == C_IDX_RELOAD + 6'(n)) w_rd_val = rel_q[n];
                end
            end
        endcase
        ack_d   = we | rd;
        rdata_d = w_read ? w_rd_val : 32'd0;

        // Reading the low word freezes the upper word so a later HI read is coherent
        if (w_read && w_idx == C_IDX_CYC_LO) begin
            hi_snap_d = w_cyc_ext[63:32];
        end

        // Watchdog: a reload on the expiry edge cancels the expiry
        if (we && w_idx == C_IDX_WDOG) begin
            wdog_d = wdata;
        end else if (wdog_q != 32'd0) begin
            wdog_d = wdog_q - 32'd1;
            if (wdog_q == 32'd1 && !done_q) begin
                done_d = 1'b1;
                exit_d = 8'hFF;
            end
        end

        // Software finish takes precedence over a watchdog expiry on the same edge
        if (we && w_idx == C_IDX_FINISH && wdata[0] && !done_q) begin
            done_d = 1'b1;
            exit_d = wdata[15:8];
        end

        // Timers: expiry is flagged even when software reloads on that edge
        for (int n = 0; n < NUM_TIMERS; n++) begin
            if (tmr_q[n] == 32'd1) w_set[n] = 1'b1;
            if (we && w_idx == C_IDX_TIMER + 6'(n)) begin
                tmr_d[n] = wdata;
            end else if (tmr_q[n] == 32'd1) begin
                tmr_d[n] = rel_q[n];
            end else if (tmr_q[n] != 32'd0) begin
                tmr_d[n] = tmr_q[n] - 32'd1;
            end
            if (we && w_idx == C_IDX_RELOAD + 6'(n)) rel_d[n] = wdata;
        end

        // Status is write-1-to-clear; a hardware set on the same edge wins
        status_d = status_q;
        if (we && w_idx == C_IDX_STATUS) status_d = status_d & ~wdata[NUM_TIMERS-1:0];
        status_d = status_d | w_set;

        if (we && w_idx == C_IDX_ENABLE) enable_d = wdata[NUM_TIMERS-1:0];
    end

    // State registers, cleared asynchronously by nreset
    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            cyc_q     <= '0;
            hi_snap_q <= '0;
            rdata_q   <= '0;
            ack_q     <= 1'b0;
            done_q    <= 1'b0;
            exit_q    <= '0;
            wdog_q    <= '0;
            status_q  <= '0;
            enable_q  <= '0;
            for (int n = 0; n < NUM_TIMERS; n++) begin
                tmr_q[n] <= '0;
                rel_q[n] <= '0;
            end
        end else begin
            cyc_q     <= cyc_d;
            hi_snap_q <= hi_snap_d;
            rdata_q   <= rdata_d;
            ack_q     <= ack_d;
            done_q    <= done_d;
            exit_q    <= exit_d;
            wdog_q    <= wdog_d;
            status_q  <= status_d;
            enable_q  <= enable_d;
            tmr_q     <= tmr_d;
            rel_q     <= rel_d;
        end
    end

    assign rdata     = rdata_q;
    assign ack       = ack_q;
    assign done      = done_q;
    assign exit_code = exit_q;
    assign irq       = |(status_q & enable_q);

    generate
        if (SIM_FINISH) begin : g_sim_finish
            // End the run on the first edge that observes the finish flag
            always @(posedge clk) begin
                if (done_q) $finish;
            end
        end
    endgenerate

endmodule
`default_nettype wire
